// File: rtl/axi3_pkg.sv
// Shared AXI3 encodings and small helpers for the SRAM responder.
package axi3_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   localparam logic [2:0] SIZE_4B = 3'b010;

   typedef enum logic {R_IDLE, R_BURST} r_state_t;
   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

   // The response encoding is ordered by severity, so the numeric maximum is the worst.
   function automatic logic [1:0] worst_resp(input logic [1:0] a, input logic [1:0] b);
      return (a > b) ? a : b;
   endfunction

   // WRAP, the reserved burst type and any size other than 4 bytes are unsupported.
   function automatic logic cfg_bad(input logic [1:0] burst, input logic [2:0] size);
      return (burst != BURST_FIXED && burst != BURST_INCR) || (size != SIZE_4B);
   endfunction

endpackage

// File: rtl/axi3_sram_mem.sv
// Word-wide SRAM with one registered read port and one byte-enabled write port.
module axi3_sram_mem #(
   parameter int DEPTH = 16384,
   parameter int IDX_W = $clog2(DEPTH)
) (
   input  logic             aclk,
   input  logic             rd_en,
   input  logic [IDX_W-1:0] rd_idx,
   output logic [31:0]      rd_data,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [3:0]       wr_strb,
   input  logic [31:0]      wr_data
);

   logic [31:0] mem [DEPTH];

   // NOTE: the array and its read register carry no reset so they map onto block RAM;
   // contents deliberately survive aresetn.
   // NOTE: read and write share one block with non-blocking assignments, so a read of the
   // word being written in the same cycle returns the old contents.
   always_ff @(posedge aclk) begin
      if (rd_en) rd_data <= mem[rd_idx];
      for (int b = 0; b < 4; b++) begin
         if (wr_en && wr_strb[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
   end

endmodule

// File: rtl/axi3_sram_slave.sv
// AXI3 slave serving FIXED/INCR bursts from on-chip SRAM; independent read and write
// channels with one outstanding transaction each.
module axi3_sram_slave
   import axi3_pkg::*;
#(
   parameter logic [31:0] ADDR_BASE = 32'h1c00_0000,
   parameter int          DEPTH     = 16384,
   parameter int          ID_W      = 4
) (
   input  logic            aclk,
   input  logic            aresetn,
   input  logic [ID_W-1:0] arid,
   input  logic [31:0]     araddr,
   input  logic [7:0]      arlen,
   input  logic [2:0]      arsize,
   input  logic [1:0]      arburst,
   input  logic            arvalid,
   output logic            arready,
   output logic [ID_W-1:0] rid,
   output logic [31:0]     rdata,
   output logic [1:0]      rresp,
   output logic            rlast,
   output logic            rvalid,
   input  logic            rready,
   input  logic [ID_W-1:0] awid,
   input  logic [31:0]     awaddr,
   input  logic [7:0]      awlen,
   input  logic [2:0]      awsize,
   input  logic [1:0]      awburst,
   input  logic            awvalid,
   output logic            awready,
   input  logic [ID_W-1:0] wid,
   input  logic [31:0]     wdata,
   input  logic [3:0]      wstrb,
   input  logic            wlast,
   input  logic            wvalid,
   output logic            wready,
   output logic [ID_W-1:0] bid,
   output logic [1:0]      bresp,
   output logic            bvalid,
   input  logic            bready
);

   localparam int          IDX_W = $clog2(DEPTH);
   localparam logic [31:0] SPAN  = 32'(4 * DEPTH);

   // Offset arithmetic wraps below the base, so one unsigned compare covers both ends.
   function automatic logic [1:0] beat_resp(input logic cfg_err, input logic [31:0] addr);
      logic [31:0] off;
      off = addr - ADDR_BASE;
      if (cfg_err)     return RESP_SLVERR;
      if (off >= SPAN) return RESP_DECERR;
      return RESP_OKAY;
   endfunction

   function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] addr);
      logic [31:0] off;
      off = addr - ADDR_BASE;
      return off[IDX_W+1:2];
   endfunction

   logic unused_bits;
   assign unused_bits = ^{arlen[7:4], awlen[7:4], araddr[1:0], awaddr[1:0]};

   // ---------------- read channel ----------------
   r_state_t        r_state, r_state_nxt;
   logic [ID_W-1:0] r_id;
   logic [31:0]     r_addr, r_addr_nxt;
   logic [4:0]      r_left;
   logic            r_fixed, r_cfg_err, r_final, ar_hs, r_hs;
   logic [1:0]      r_resp_c;
   logic            mem_rd_en;
   logic [IDX_W-1:0] mem_rd_idx;
   logic [31:0]     mem_rd_data;

   always_ff @(posedge aclk) begin
      if (!aresetn) r_state <= R_IDLE;
      else          r_state <= r_state_nxt;
   end

   // NOTE: every output of this block is defaulted first so no path leaves one unassigned (no latch).
   always_comb begin
      r_state_nxt = r_state;
      arready     = 1'b0;
      rvalid      = 1'b0;
      case (r_state)
         R_IDLE: begin
            arready = 1'b1;
            if (arvalid) r_state_nxt = R_BURST;
         end
         R_BURST: begin
            rvalid = 1'b1;
            if (rready && r_final) r_state_nxt = R_IDLE;
         end
         default: r_state_nxt = R_IDLE;
      endcase
   end

   assign ar_hs      = arvalid && arready;
   assign r_hs       = rvalid && rready;
   assign r_final    = (r_left == 5'd1);
   assign r_addr_nxt = r_fixed ? r_addr : r_addr + 32'd4;
   assign r_resp_c   = beat_resp(r_cfg_err, r_addr);

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         r_id      <= '0;
         r_addr    <= '0;
         r_left    <= '0;
         r_fixed   <= 1'b0;
         r_cfg_err <= 1'b0;
      end else if (ar_hs) begin
         r_id      <= arid;
         r_addr    <= {araddr[31:2], 2'b00};
         r_left    <= {1'b0, arlen[3:0]} + 5'd1;
         r_fixed   <= (arburst == BURST_FIXED);
         r_cfg_err <= cfg_bad(arburst, arsize);
      end else if (r_hs) begin
         r_addr <= r_addr_nxt;
         r_left <= r_left - 5'd1;
      end
   end

   // Fetch the first word on AR and each following word on the beat before it is shown.
   assign mem_rd_en  = ar_hs || (r_hs && !r_final);
   assign mem_rd_idx = ar_hs ? word_idx(araddr) : word_idx(r_addr_nxt);

   assign rid   = r_id;
   assign rresp = rvalid ? r_resp_c : RESP_OKAY;
   assign rlast = rvalid && r_final;
   assign rdata = (rvalid && r_resp_c == RESP_OKAY) ? mem_rd_data : 32'h0;

   // ---------------- write channel ----------------
   w_state_t        w_state, w_state_nxt;
   logic [ID_W-1:0] w_id;
   logic [31:0]     w_addr;
   logic [4:0]      w_left;
   logic            w_fixed, w_cfg_err, aw_hs, w_hs, count_err, id_err;
   logic [1:0]      w_resp, w_beat_resp, w_beat_total;

   always_ff @(posedge aclk) begin
      if (!aresetn) w_state <= W_IDLE;
      else          w_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = w_state;
      awready     = 1'b0;
      wready      = 1'b0;
      bvalid      = 1'b0;
      case (w_state)
         W_IDLE: begin
            awready = 1'b1;
            if (awvalid) w_state_nxt = W_DATA;
         end
         W_DATA: begin
            wready = 1'b1;
            if (wvalid && wlast) w_state_nxt = W_RESP;
         end
         W_RESP: begin
            bvalid = 1'b1;
            if (bready) w_state_nxt = W_IDLE;
         end
         default: w_state_nxt = W_IDLE;
      endcase
   end

   assign aw_hs       = awvalid && awready;
   assign w_hs        = wvalid && wready;
   assign w_beat_resp = beat_resp(w_cfg_err, w_addr);
   // A non-last beat with at most one beat left means wlast came late.
   assign count_err   = wlast ? (w_left != 5'd1) : (w_left <= 5'd1);
   assign id_err      = (wid != w_id);
   assign w_beat_total = worst_resp(w_beat_resp,
                                    (count_err || id_err) ? RESP_SLVERR : RESP_OKAY);

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         w_id      <= '0;
         w_addr    <= '0;
         w_left    <= '0;
         w_fixed   <= 1'b0;
         w_cfg_err <= 1'b0;
         w_resp    <= RESP_OKAY;
      end else if (aw_hs) begin
         w_id      <= awid;
         w_addr    <= {awaddr[31:2], 2'b00};
         w_left    <= {1'b0, awlen[3:0]} + 5'd1;
         w_fixed   <= (awburst == BURST_FIXED);
         w_cfg_err <= cfg_bad(awburst, awsize);
         w_resp    <= RESP_OKAY;
      end else if (w_hs) begin
         w_addr <= w_fixed ? w_addr : w_addr + 32'd4;
         w_left <= (w_left == 5'd0) ? 5'd0 : w_left - 5'd1;
         w_resp <= worst_resp(w_resp, w_beat_total);
      end
   end

   assign bid   = w_id;
   assign bresp = bvalid ? w_resp : RESP_OKAY;

   axi3_sram_mem #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_mem (
      .aclk    (aclk),
      .rd_en   (mem_rd_en),
      .rd_idx  (mem_rd_idx),
      .rd_data (mem_rd_data),
      .wr_en   (w_hs && w_beat_resp == RESP_OKAY),
      .wr_idx  (word_idx(w_addr)),
      .wr_strb (wstrb),
      .wr_data (wdata)
   );

endmodule

// File: tb/tb_axi3_sram_slave.sv
// Scoreboard bench for axi3_sram_slave: a word-array reference model predicts every R beat
// and B response; a monitor compares them as the DUT presents them.
module tb_axi3_sram_slave;
   import axi3_pkg::*;

   localparam logic [31:0] BASE  = 32'h1c00_0000;
   localparam int          DEPTH = 16384;
   localparam int          ID_W  = 4;

   logic            aclk, aresetn;
   logic [ID_W-1:0] arid, rid, awid, wid, bid;
   logic [31:0]     araddr, rdata, awaddr, wdata;
   logic [7:0]      arlen, awlen;
   logic [2:0]      arsize, awsize;
   logic [1:0]      arburst, rresp, awburst, bresp;
   logic            arvalid, arready, rlast, rvalid, rready;
   logic            awvalid, awready, wlast, wvalid, wready, bvalid, bready;
   logic [3:0]      wstrb;

   axi3_sram_slave #(.ADDR_BASE(BASE), .DEPTH(DEPTH), .ID_W(ID_W)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .awvalid(awvalid), .awready(awready),
      .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
   );

   initial begin
      aclk = 1'b0;
      forever #5 aclk = ~aclk;
   end

   typedef struct {
      logic [3:0]  id;
      logic [31:0] data;
      logic [1:0]  resp;
      logic        last;
   } r_exp_t;

   typedef struct {
      logic [3:0] id;
      logic [1:0] resp;
   } b_exp_t;

   r_exp_t      rq[$];
   b_exp_t      bq[$];
   logic [31:0] ref_mem [int];
   int          n_tests = 0;
   int          n_fail  = 0;
   bit          mon_en  = 1'b0;
   int          rready_mode = 0;
   int          bready_mode = 0;
   bit          rpat[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s: handshake did not happen within the cycle budget", name);
   endtask

   // ---------------- reference model ----------------
   function automatic logic [1:0] model_beat(input logic [31:0] a, input logic [1:0] burst,
                                             input logic [2:0] size);
      if (burst == 2'b10 || burst == 2'b11 || size != 3'b010) return RESP_SLVERR;
      if (a < BASE || a >= BASE + 32'(4 * DEPTH)) return RESP_DECERR;
      return RESP_OKAY;
   endfunction

   function automatic int word_of(input logic [31:0] a);
      return int'((a - BASE) >> 2);
   endfunction

   function automatic int severity(input logic [1:0] r);
      case (r)
         RESP_DECERR: return 2;
         RESP_SLVERR: return 1;
         default:     return 0;
      endcase
   endfunction

   function automatic logic [1:0] resp_of(input int sev);
      case (sev)
         2:       return RESP_DECERR;
         1:       return RESP_SLVERR;
         default: return RESP_OKAY;
      endcase
   endfunction

   function automatic logic [31:0] beat_addr(input logic [31:0] addr, input logic [1:0] burst,
                                             input int b);
      logic [31:0] al;
      al = {addr[31:2], 2'b00};
      return (burst == 2'b00) ? al : al + 32'(4 * b);
   endfunction

   task automatic push_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
      r_exp_t      e;
      logic [31:0] a;
      int          n;
      n = int'(len[3:0]) + 1;
      for (int b = 0; b < n; b++) begin
         a      = beat_addr(addr, burst, b);
         e.id   = id;
         e.resp = model_beat(a, burst, size);
         e.last = (b == n - 1);
         e.data = (e.resp == RESP_OKAY) ? ref_mem[word_of(a)] : 32'h0;
         rq.push_back(e);
      end
   endtask

   task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      int          w;
      logic [31:0] cur;
      w   = word_of(a);
      cur = ref_mem.exists(w) ? ref_mem[w] : 32'hxxxx_xxxx;
      for (int b = 0; b < 4; b++) if (s[b]) cur[8*b +: 8] = d[8*b +: 8];
      ref_mem[w] = cur;
   endtask

   // ---------------- ready drivers ----------------
   initial begin
      forever begin
         @(posedge aclk);
         #1;
         case (rready_mode)
            0:       rready = 1'b1;
            1:       rready = 1'($urandom_range(0, 1));
            2:       rready = (rpat.size() > 0) ? rpat.pop_front() : 1'b1;
            default: rready = 1'b0;
         endcase
         bready = (bready_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // ---------------- monitor ----------------
   logic            stall = 1'b0;
   logic [38:0]     stall_val;
   r_exp_t          re;
   b_exp_t          be;

   initial begin
      forever begin
         @(negedge aclk);
         if (!mon_en) begin
            stall = 1'b0;
         end else begin
            if (stall) check("r_stall_hold", {rvalid, rid, rresp, rlast, rdata}, {1'b1, stall_val});
            if (rvalid && rready) begin
               if (rq.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL r_unexpected: got beat id=%h data=%h, expected none", rid, rdata);
               end else begin
                  re = rq.pop_front();
                  check("r_beat", {rid, rresp, rlast, rdata}, {re.id, re.resp, re.last, re.data});
               end
            end
            stall     = rvalid && !rready;
            stall_val = {rid, rresp, rlast, rdata};
            if (bvalid && bready) begin
               if (bq.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL b_unexpected: got bid=%h bresp=%h, expected none", bid, bresp);
               end else begin
                  be = bq.pop_front();
                  check("b_resp", {bid, bresp}, {be.id, be.resp});
               end
            end
         end
      end
   end

   // ---------------- stimulus tasks ----------------
   task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
      bit ok = 1'b0;
      @(posedge aclk);
      #1;
      arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
      for (int k = 0; k < 200 && !ok; k++) begin
         @(negedge aclk);
         if (arready) ok = 1'b1;
         else @(posedge aclk);
      end
      if (ok) push_read(id, addr, len, size, burst);
      else fail_now("ar_handshake");
      @(posedge aclk);
      #1;
      arvalid = 1'b0;
   endtask

   task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input int nbeats,
                           input int bad_id_beat, input bit rand_strb, input bit use_fix,
                           input logic [31:0] fix_data, input logic [3:0] fix_strb);
      bit          ok = 1'b0;
      int          sev = 0;
      logic [31:0] a, d;
      logic [3:0]  s;
      logic [1:0]  r;
      b_exp_t      e;
      @(posedge aclk);
      #1;
      awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
      for (int k = 0; k < 200 && !ok; k++) begin
         @(negedge aclk);
         if (awready) ok = 1'b1;
         else @(posedge aclk);
      end
      @(posedge aclk);
      #1;
      awvalid = 1'b0;
      if (!ok) begin
         fail_now("aw_handshake");
         return;
      end
      for (int i = 0; i < nbeats; i++) begin
         d = use_fix ? fix_data : $urandom;
         s = use_fix ? fix_strb : (rand_strb ? 4'($urandom_range(0, 15)) : 4'hf);
         wid = (i == bad_id_beat) ? (id ^ 4'h1) : id;
         wdata = d; wstrb = s; wlast = (i == nbeats - 1); wvalid = 1'b1;
         ok = 1'b0;
         for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge aclk);
            if (wready) ok = 1'b1;
            else @(posedge aclk);
         end
         if (!ok) begin
            fail_now("w_handshake");
            break;
         end
         a = beat_addr(addr, burst, i);
         r = model_beat(a, burst, size);
         if (r == RESP_OKAY) model_write(a, d, s);
         if (severity(r) > sev) sev = severity(r);
         if (wid != id && sev < 1) sev = 1;
         if (i == nbeats - 1) begin
            if (nbeats != int'(len[3:0]) + 1 && sev < 1) sev = 1;
            e.id = id;
            e.resp = resp_of(sev);
            bq.push_back(e);
         end
         @(posedge aclk);
         #1;
      end
      wvalid = 1'b0;
      wlast  = 1'b0;
   endtask

   task automatic wr_full(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
      do_write(id, addr, len, SIZE_4B, BURST_INCR, int'(len[3:0]) + 1, -1, 1'b0, 1'b0, 32'h0, 4'h0);
   endtask

   task automatic wait_idle();
      bit ok = 1'b0;
      for (int k = 0; k < 2000 && !ok; k++) begin
         @(negedge aclk);
         if (rq.size() == 0 && bq.size() == 0 && !rvalid && !bvalid) ok = 1'b1;
      end
      if (!ok) fail_now("drain");
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, expected $finish");
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   initial begin
      aresetn = 1'b0;
      arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0; wlast = 1'b0;
      arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0;
      awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0;
      wid = '0; wdata = '0; wstrb = '0;
      rready = 1'b1; bready = 1'b1;
      repeat (3) @(posedge aclk);
      @(negedge aclk);
      check("reset_ready", {arready, awready}, 2'b11);
      check("reset_valid", {rvalid, rlast, wready, bvalid}, 4'b0000);
      check("reset_fields", {rid, bid, rresp, bresp, rdata}, '0);
      @(posedge aclk);
      #1;
      aresetn = 1'b1;
      mon_en  = 1'b1;

      // Preload words 0..127 and the top four words with known data.
      for (int i = 0; i < 8; i++) wr_full(4'(i), BASE + 32'(64 * i), 8'd15);
      wr_full(4'h9, BASE + 32'(4 * (DEPTH - 4)), 8'd3);
      wait_idle();

      // Basic INCR read, ID echoed, rlast on beat 4.
      do_read(4'h5, BASE, 8'd3, SIZE_4B, BURST_INCR);
      wait_idle();

      // Partial strobes over a zeroed word.
      do_write(4'h2, BASE + 32'd8, 8'd0, SIZE_4B, BURST_INCR, 1, -1, 1'b0, 1'b1, 32'h0, 4'hf);
      do_write(4'h2, BASE + 32'd8, 8'd0, SIZE_4B, BURST_INCR, 1, -1, 1'b0, 1'b1, 32'hAABBCCDD, 4'b0101);
      wait_idle();
      do_read(4'h3, BASE + 32'd8, 8'd0, SIZE_4B, BURST_INCR);
      wait_idle();

      // Back-pressure mid-burst: data must hold while stalled.
      rpat = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      rready_mode = 2;
      do_read(4'h6, BASE + 32'd16, 8'd7, SIZE_4B, BURST_INCR);
      wait_idle();
      rready_mode = 0;

      // Top of memory, below base, and ignored arlen[7:4].
      do_read(4'h7, BASE + 32'(4 * DEPTH - 4), 8'd1, SIZE_4B, BURST_INCR);
      do_read(4'h8, BASE - 32'd8, 8'd3, SIZE_4B, BURST_INCR);
      do_read(4'h1, BASE + 32'd4, 8'hF2, SIZE_4B, BURST_FIXED);
      wait_idle();

      // Write error cases, then confirm memory contents.
      do_write(4'hA, BASE + 32'd40, 8'd3, SIZE_4B, BURST_INCR, 2, -1, 1'b1, 1'b0, 32'h0, 4'h0);
      do_write(4'hB, BASE + 32'd16, 8'd1, SIZE_4B, BURST_WRAP, 2, -1, 1'b0, 1'b0, 32'h0, 4'h0);
      do_write(4'hC, BASE + 32'd24, 8'd1, 3'b001, BURST_INCR, 2, -1, 1'b0, 1'b0, 32'h0, 4'h0);
      do_write(4'hD, BASE + 32'd48, 8'd2, SIZE_4B, BURST_INCR, 3, 1, 1'b0, 1'b0, 32'h0, 4'h0);
      do_write(4'hE, BASE + 32'(4 * DEPTH - 4), 8'd1, SIZE_4B, BURST_INCR, 2, -1, 1'b0, 1'b0, 32'h0, 4'h0);
      do_write(4'hF, BASE + 32'd56, 8'd2, SIZE_4B, BURST_FIXED, 4, -1, 1'b0, 1'b0, 32'h0, 4'h0);
      wait_idle();
      do_read(4'h4, BASE + 32'd16, 8'd15, SIZE_4B, BURST_INCR);
      do_read(4'h4, BASE + 32'd16, 8'd1, 3'b011, BURST_INCR);
      do_read(4'h4, BASE + 32'd16, 8'd1, 2'b11 == 2'b11 ? SIZE_4B : SIZE_4B, 2'b11);
      do_read(4'h4, BASE + 32'(4 * DEPTH - 8), 8'd1, SIZE_4B, BURST_INCR);
      wait_idle();

      // Concurrent traffic: reads in words 0..46, writes in words 64..127, random ready.
      rready_mode = 1;
      bready_mode = 1;
      fork
         for (int i = 0; i < 8; i++)
            do_read(4'($urandom), BASE + 32'(4 * $urandom_range(0, 31)), 8'($urandom_range(0, 15)),
                    SIZE_4B, ($urandom_range(0, 3) == 0) ? BURST_FIXED : BURST_INCR);
         for (int i = 0; i < 8; i++) begin
            automatic int len = $urandom_range(0, 15);
            do_write(4'($urandom), BASE + 32'(4 * (64 + $urandom_range(0, 48))), 8'(len), SIZE_4B,
                     ($urandom_range(0, 3) == 0) ? BURST_FIXED : BURST_INCR, len + 1, -1, 1'b1,
                     1'b0, 32'h0, 4'h0);
         end
      join
      wait_idle();
      rready_mode = 0;
      bready_mode = 0;
      for (int i = 0; i < 4; i++) do_read(4'(i), BASE + 32'(256 + 64 * i), 8'd15, SIZE_4B, BURST_INCR);
      wait_idle();

      // Reset in the middle of a read and a write burst.
      mon_en = 1'b0;
      rready_mode = 3;
      @(posedge aclk);
      #1;
      arid = 4'h3; araddr = BASE; arlen = 8'd15; arsize = SIZE_4B; arburst = BURST_INCR; arvalid = 1'b1;
      awid = 4'h6; awaddr = BASE + 32'd800; awlen = 8'd7; awsize = SIZE_4B; awburst = BURST_INCR;
      awvalid = 1'b1;
      @(posedge aclk);
      #1;
      arvalid = 1'b0;
      awvalid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         wid = 4'h6; wdata = $urandom; wstrb = 4'hf; wlast = 1'b0; wvalid = 1'b1;
         @(negedge aclk);
         check("rst_wready", wready, 1'b1);
         model_write(BASE + 32'(800 + 4 * i), wdata, 4'hf);
         @(posedge aclk);
         #1;
      end
      wvalid = 1'b0;
      aresetn = 1'b0;
      @(negedge aclk);
      check("rst_pre_rvalid", rvalid, 1'b1);
      @(posedge aclk);
      @(negedge aclk);
      check("rst_valids", {rvalid, rlast, wready, bvalid}, 4'b0000);
      check("rst_readies", {arready, awready}, 2'b11);
      @(posedge aclk);
      #1;
      aresetn = 1'b1;
      rq.delete();
      bq.delete();
      rready_mode = 0;
      mon_en = 1'b1;
      do_read(4'h2, BASE + 32'd800, 8'd2, SIZE_4B, BURST_INCR);
      wait_idle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
